// File: rtl/regfl_arb2.sv
// regfl_arb2: two-client arbiter in front of an external 4x8 register file.
// Each accepted access takes two cycles. The handshake happens in an IDLE
// cycle, and the register file is driven in the ACCESS cycle that follows.
// Read data is captured at the end of ACCESS and presented with a one-cycle
// rvalid pulse on the owning client's port.
//
// Build option: define REGFL_ARB_RR_EN for round-robin arbitration. The default
// build uses fixed priority, with client 0 winning ties.
//
// state  | meaning
// IDLE   | accepting requests; grants are combinational from req0/req1
// ACCESS | latched access drives the register file ports; no grants
module regfl_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [1:0] addr0,
    input  logic [1:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       wr_e,
    output logic [1:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [1:0] rd_addr,
    input  logic [7:0] rd_data
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t     state;
    logic       owner;
    logic       lat_we;
    logic [1:0] lat_addr;
    logic [7:0] lat_wdata;
    logic       win1;
    logic       hs;

`ifdef REGFL_ARB_RR_EN
    // Preferred client on a tie; toggles after every handshake
    logic       ptr;
`endif

    // Winner selection: on a tie the preferred client wins, otherwise the lone requester wins
    always_comb begin
        win1 = 1'b0;
`ifdef REGFL_ARB_RR_EN
        if (req0 && req1) begin
            win1 = ptr;
        end else begin
            win1 = req1;
        end
`else
        win1 = req1 && !req0;
`endif
    end

    // A handshake is possible in any IDLE cycle that has a requester.
    // Gating with rst_n holds the grants low while reset is applied.
    assign hs   = (state == IDLE) && (req0 || req1);
    assign gnt0 = rst_n && hs && !win1;
    assign gnt1 = rst_n && hs && win1;

    // Register file ports follow the latched access; writes are enabled only in ACCESS
    assign wr_e    = (state == ACCESS) && lat_we;
    assign wr_addr = lat_addr;
    assign rd_addr = lat_addr;
    assign wr_data = lat_wdata;

    // FSM: latch the winning request, run the access, capture read data for its owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 2'd0;
            lat_wdata <= 8'h00;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= 8'h00;
            rdata1    <= 8'h00;
`ifdef REGFL_ARB_RR_EN
            ptr       <= 1'b0;
`endif
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        owner     <= win1;
                        lat_we    <= win1 ? we1 : we0;
                        lat_addr  <= win1 ? addr1 : addr0;
                        lat_wdata <= win1 ? wdata1 : wdata0;
                        state     <= ACCESS;
`ifdef REGFL_ARB_RR_EN
                        ptr       <= ~ptr;
`endif
                    end
                end
                ACCESS: begin
                    // rd_data is combinational from rd_addr and is stable by the end of ACCESS
                    if (!lat_we) begin
                        if (owner) begin
                            rvalid1 <= 1'b1;
                            rdata1  <= rd_data;
                        end else begin
                            rvalid0 <= 1'b1;
                            rdata0  <= rd_data;
                        end
                    end
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sanity properties on the client-facing handshake
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(rvalid0 && rvalid1));
    a_access_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ACCESS) |=> (state == IDLE));

endmodule

// File: doc/regfl_arb2.md
REGFL_ARB2 -- requirements
Module: regfl_arb2

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports req0/req1  input  1  access request from client 0/1.
REQ-004 SHALL have ports we0/we1  input  1  access type for client 0/1; 1 = write, 0 = read.
REQ-005 SHALL have ports addr0/addr1  input  2  register address for client 0/1.
REQ-006 SHALL have ports wdata0/wdata1  input  8  write data for client 0/1.
REQ-007 SHALL have ports gnt0/gnt1  output  1  handshake accept for client 0/1; combinational in IDLE.
REQ-008 SHALL have ports rvalid0/rvalid1  output  1  one-cycle read-data-valid pulse for client 0/1.
REQ-009 SHALL have ports rdata0/rdata1  output  8  captured read data for client 0/1.
REQ-010 SHALL have ports wr_e, wr_addr[1:0], wr_data[7:0], rd_addr[1:0]  output  drive the 4x8 register file ports.
REQ-011 SHALL have port rd_data  input  8  combinational read data from the register file.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and ACCESS.
REQ-013 IDLE: at most one of gnt0/gnt1 high, and only if the corresponding req is high; handshake = reqN && gntN.
REQ-014 On a handshake, SHALL latch winner id, we, addr, wdata and go to ACCESS next cycle; with no req, stay IDLE.
REQ-015 ACCESS: gnt0 = gnt1 = 0; wr_e = latched we; wr_addr = rd_addr = latched addr; wr_data = latched wdata; next state IDLE unconditionally.
REQ-016 IDLE: wr_e = 0; wr_addr, rd_addr, wr_data hold their last latched values.
REQ-017 Write latency: handshake in cycle T -> wr_e high in T+1 only; register updated at the end of T+1.
REQ-018 Read: rd_data sampled at the end of ACCESS (T+1) into the owner's rdata; the owner's rvalid is high for exactly cycle T+2; the other client's rdata is unchanged.
REQ-019 rdataN SHALL hold its value until the next read completes for client N; writes never modify rdata.
REQ-020 Throughput: at most one access per 2 cycles; a new handshake may occur in the same cycle as the previous read's rvalid.
REQ-021 Client SHALL hold req/we/addr/wdata stable until its handshake; the block ignores field changes outside the handshake cycle.
REQ-022 Simultaneous req0 and req1: winner per arbitration policy (REQ-026/027); the loser stays pending with no grant.
REQ-023 Write then read of the same address by any clients in consecutive handshakes SHALL return the newly written value.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, priority pointer = client 0, wr_e = 0, gnt0/1 = 0, rvalid0/1 = 0, rdata0/1 = 0x00, latched addr/wdata/we/winner = 0.
REQ-025 Reset during ACCESS SHALL abort the access: wr_e drops asynchronously and no rvalid is issued after release.

Configuration
REQ-026 With REGFL_ARB_RR_EN defined: round-robin arbitration; the pointer selects the preferred client and flips to the other client after every handshake; after reset client 0 is preferred.
REQ-027 Without REGFL_ARB_RR_EN: fixed priority; client 0 always wins ties, and the pointer is absent.

Verification
REQ-028 After reset, req0=1, we0=1, addr0=2, wdata0=0xA5 -> gnt0=1 in the same cycle; next cycle wr_e=1, wr_addr=2, wr_data=0xA5; then req1 read addr1=2 -> rvalid1=1 two cycles after its handshake with rdata1=0xA5.
REQ-029 Write 0x11, 0x22, 0x33, 0x44 to addresses 0-3, then read 3,2,1,0 via client 0 -> rdata0 = 0x44, 0x33, 0x22, 0x11 on successive rvalid0 pulses, 2 cycles apart.
REQ-030 With REGFL_ARB_RR_EN defined, req0 and req1 held high continuously from reset -> grant order 0,1,0,1 with one grant every 2 cycles; without the macro -> gnt0 on every IDLE cycle and gnt1 never high.
REQ-031 Client 1 issues a read of address 1 while client 0 is idle -> rvalid0 stays 0 and rdata0 is unchanged; only rvalid1 pulses.
REQ-032 rst_n asserted low in the ACCESS cycle of a write of 0xFF to address 3 -> wr_e=0 immediately and all outputs take reset values; after release, a simultaneous req0/req1 grants client 0 first.
